// File: rtl/iddr_tap_calib.sv
// Input-delay calibration sequencer: sweeps the delay tap, checks a training word
// at each tap, then loads the centre of the longest passing window.
module iddr_tap_calib #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned TAP_W   = 5,
  parameter int unsigned TAPS    = 32,
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned SAMPLES = 16,
  parameter logic [WIDTH-1:0] PATTERN_Q1 = '0,
  parameter logic [WIDTH-1:0] PATTERN_Q2 = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  output logic [TAP_W-1:0] tap_out,
  output logic             tap_load,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TAP_W-1:0] win_start,
  output logic [TAP_W:0]   win_len
);

  localparam int unsigned LEN_W   = TAP_W + 1;
  localparam int unsigned CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [TAP_W-1:0] TAP_LAST     = TAP_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] SAMPLES_LAST = CNT_W'(SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_FINAL, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic [TAP_W-1:0]  run_start_q, run_start_d, best_start_q, best_start_d;
  logic [LEN_W-1:0]  run_len_q, run_len_d, best_len_q, best_len_d;
  logic [TAP_W-1:0]  tap_out_q, tap_out_d, win_start_q, win_start_d;
  logic [LEN_W-1:0]  win_len_q, win_len_d;
  logic              tap_load_q, tap_load_d, busy_q, busy_d;
  logic              done_q, done_d, fail_q, fail_d;

  logic              mismatch, pass, close_run;
  logic [TAP_W-1:0]  cur_start, cl_start, nb_start;
  logic [LEN_W-1:0]  cur_len, cl_len, nb_len, centre;

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    best_start_d = best_start_q;
    best_len_d  = best_len_q;
    tap_out_d   = tap_out_q;
    win_start_d = win_start_q;
    win_len_d   = win_len_q;
    tap_load_d  = 1'b0;
    done_d      = done_q;
    fail_d      = fail_q;
    mismatch    = (q1 != PATTERN_Q1) || (q2 != PATTERN_Q2);
    pass        = !flag_q;
    cur_start   = (run_len_q == '0) ? tap_q : run_start_q;
    cur_len     = run_len_q + LEN_W'(1);
    close_run   = !pass || (tap_q == TAP_LAST);
    cl_start    = pass ? cur_start : run_start_q;
    cl_len      = pass ? cur_len : run_len_q;
    nb_start    = best_start_q;
    nb_len      = best_len_q;
    centre      = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          tap_d        = '0;
          tap_out_d    = '0;
          tap_load_d   = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          win_start_d  = '0;
          win_len_d    = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
        end
      end
      S_LOAD: begin
        flag_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        flag_d = flag_q | mismatch;
        if (cnt_q == SAMPLES_LAST) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        // Strictly-longer replacement keeps the earliest of equal windows
        if (close_run && (cl_len > best_len_q)) begin
          nb_start = cl_start;
          nb_len   = cl_len;
        end
        best_start_d = nb_start;
        best_len_d   = nb_len;
        run_start_d  = pass ? cur_start : run_start_q;
        run_len_d    = close_run ? '0 : cur_len;
        tap_load_d   = 1'b1;
        if (tap_q == TAP_LAST) begin
          centre      = LEN_W'(nb_start) + (nb_len >> 1);
          tap_out_d   = (nb_len != '0) ? centre[TAP_W-1:0] : '0;
          fail_d      = (nb_len == '0);
          win_start_d = nb_start;
          win_len_d   = nb_len;
          state_d     = S_FINAL;
        end else begin
          tap_d     = tap_q + TAP_W'(1);
          tap_out_d = tap_q + TAP_W'(1);
          state_d   = S_LOAD;
        end
      end
      S_FINAL: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      tap_out_q    <= '0;
      win_start_q  <= '0;
      win_len_q    <= '0;
      tap_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      tap_out_q    <= tap_out_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      tap_load_q   <= tap_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign tap_out   = tap_out_q;
  assign tap_load  = tap_load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign win_start = win_start_q;
  assign win_len   = win_len_q;

endmodule

// File: tb/tb_iddr_tap_calib.sv
// Directed bench for iddr_tap_calib: the training word seen on q1/q2 depends on the
// tap currently applied, emulating a delay element with per-tap bad positions.
module tb_iddr_tap_calib;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned TAP_W = 5;
  localparam logic [1:0]  P1    = 2'b01;
  localparam logic [1:0]  P2    = 2'b10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] q1, q2;
  logic [TAP_W-1:0] tap_out;
  logic             tap_load, busy, done, fail;
  logic [TAP_W-1:0] win_start;
  logic [TAP_W:0]   win_len;

  logic [3:0] bad1, bad2;
  int nchk = 0;
  int nerr = 0;
  int loads[$];

  iddr_tap_calib #(
    .WIDTH(WIDTH), .TAP_W(TAP_W), .TAPS(4), .SETTLE(2), .SAMPLES(4),
    .PATTERN_Q1(P1), .PATTERN_Q2(P2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .q1(q1), .q2(q2),
    .tap_out(tap_out), .tap_load(tap_load), .busy(busy), .done(done),
    .fail(fail), .win_start(win_start), .win_len(win_len)
  );

  always #5 clk = ~clk;

  always_comb begin
    q1 = bad1[tap_out[1:0]] ? ~P1 : P1;
    q2 = bad2[tap_out[1:0]] ? ~P2 : P2;
  end

  // Pulse start for one edge and follow the sweep until done (bounded)
  task automatic run_cal(output int cyc);
    loads.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (tap_load) loads.push_back(int'(tap_out));
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (tap_load) loads.push_back(int'(tap_out));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bad1 = '0; bad2 = '0;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({tap_out, tap_load, busy, done, fail, win_start, win_len} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got tap_out=%0d load=%b busy=%b done=%b fail=%b ws=%0d wl=%0d, want all 0",
               tap_out, tap_load, busy, done, fail, win_start, win_len);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (tap_load !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_exit: got load=%b busy=%b, want 0 0", tap_load, busy);
    end
  endtask

  task automatic test_all_pass;
    int cyc;
    int exp_loads[5] = '{0, 1, 2, 3, 2};
    bad1 = 4'b0000; bad2 = 4'b0000;
    run_cal(cyc);
    nchk++;
    if (cyc !== 33) begin
      nerr++; $display("FAIL all_pass_latency: got %0d cycles, want 33", cyc);
    end
    nchk++;
    if (loads.size() !== 5) begin
      nerr++; $display("FAIL all_pass_load_count: got %0d, want 5", loads.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        nchk++;
        if (loads[i] !== exp_loads[i]) begin
          nerr++; $display("FAIL all_pass_load%0d: got tap %0d, want %0d", i, loads[i], exp_loads[i]);
        end
      end
    end
    nchk++;
    if (win_start !== 5'd0 || win_len !== 6'd4 || tap_out !== 5'd2 || fail !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL all_pass_result: got ws=%0d wl=%0d tap=%0d fail=%b busy=%b, want 0 4 2 0 0",
               win_start, win_len, tap_out, fail, busy);
    end
  endtask

  task automatic test_edges_bad;
    int cyc;
    bad1 = 4'b1001; bad2 = 4'b0000;
    run_cal(cyc);
    nchk++;
    if (done !== 1'b1 || win_start !== 5'd1 || win_len !== 6'd2 || tap_out !== 5'd2 || fail !== 1'b0) begin
      nerr++;
      $display("FAIL edges_bad: got done=%b ws=%0d wl=%0d tap=%0d fail=%b, want 1 1 2 2 0",
               done, win_start, win_len, tap_out, fail);
    end
  endtask

  task automatic test_tie;
    int cyc;
    bad1 = 4'b1010; bad2 = 4'b0000;
    run_cal(cyc);
    nchk++;
    if (done !== 1'b1 || win_start !== 5'd0 || win_len !== 6'd1 || tap_out !== 5'd0 || fail !== 1'b0) begin
      nerr++;
      $display("FAIL tie_keeps_first: got done=%b ws=%0d wl=%0d tap=%0d fail=%b, want 1 0 1 0 0",
               done, win_start, win_len, tap_out, fail);
    end
  endtask

  task automatic test_no_window;
    int cyc;
    bad1 = 4'b0000; bad2 = 4'b1111;
    run_cal(cyc);
    nchk++;
    if (done !== 1'b1 || fail !== 1'b1 || win_len !== 6'd0 || tap_out !== 5'd0) begin
      nerr++;
      $display("FAIL no_window: got done=%b fail=%b wl=%0d tap=%0d, want 1 1 0 0",
               done, fail, win_len, tap_out);
    end
    nchk++;
    if (loads.size() !== 5) begin
      nerr++; $display("FAIL no_window_final_load: got %0d loads, want 5", loads.size());
    end
  endtask

  task automatic test_top_window;
    int cyc;
    bad1 = 4'b0011; bad2 = 4'b0000;
    run_cal(cyc);
    nchk++;
    if (done !== 1'b1 || win_start !== 5'd2 || win_len !== 6'd2 || tap_out !== 5'd3 || fail !== 1'b0) begin
      nerr++;
      $display("FAIL top_window: got done=%b ws=%0d wl=%0d tap=%0d fail=%b, want 1 2 2 3 0",
               done, win_start, win_len, tap_out, fail);
    end
  endtask

  task automatic test_abort;
    bad1 = 4'b0000; bad2 = 4'b0000;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    nchk++;
    if (busy !== 1'b1 || tap_out !== 5'd1) begin
      nerr++; $display("FAIL abort_precond: got busy=%b tap=%0d, want 1 1", busy, tap_out);
    end
    rst = 1'b1;
    #1;
    nchk++;
    if ({tap_out, tap_load, busy, done, fail, win_start, win_len} !== '0) begin
      nerr++;
      $display("FAIL abort_outputs: got tap=%0d load=%b busy=%b done=%b fail=%b ws=%0d wl=%0d, want all 0",
               tap_out, tap_load, busy, done, fail, win_start, win_len);
    end
    start = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (busy !== 1'b0 || tap_load !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL abort_idle: got busy=%b load=%b done=%b, want 0 0 0", busy, tap_load, done);
    end
  endtask

  task automatic test_start_held;
    int cyc = 0;
    int nload = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    if (tap_load) nload++;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (tap_load) nload++;
      if (cyc == 20) start = 1'b0;
    end
    nchk++;
    if (cyc !== 33 || nload !== 5) begin
      nerr++; $display("FAIL start_held_ignored: got %0d cycles %0d loads, want 33 5", cyc, nload);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nchk++;
    if (done !== 1'b0 || busy !== 1'b1 || tap_load !== 1'b1 || tap_out !== 5'd0 || win_len !== 6'd0) begin
      nerr++;
      $display("FAIL restart_clears: got done=%b busy=%b load=%b tap=%0d wl=%0d, want 0 1 1 0 0",
               done, busy, tap_load, tap_out, win_len);
    end
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    nchk++;
    if (cyc !== 33 || win_len !== 6'd4 || tap_out !== 5'd2) begin
      nerr++; $display("FAIL restart_result: got %0d cycles wl=%0d tap=%0d, want 33 4 2", cyc, win_len, tap_out);
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_edges_bad();
    test_tie();
    test_no_window();
    test_top_window();
    test_abort();
    test_start_held();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
